// File: rtl/comb_tt_checker.sv
// Response checker for small combinational blocks: rebuilds the truth table from
// (input vector, output) samples, tracks coverage and conflicts, and issues a verdict.
module comb_tt_checker #(
  parameter int unsigned             N_IN     = 3,
  parameter logic [(2**N_IN)-1:0]    EXPECTED = 8'hE8
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic                    i_w_start,
  input  logic                    i_w_valid,
  output logic                    o_w_ready,
  input  logic [N_IN-1:0]         i_w_in,
  input  logic                    i_w_out,
  output logic [(2**N_IN)-1:0]    o_w_table,
  output logic [(2**N_IN)-1:0]    o_w_covered,
  output logic                    o_w_conflict,
  output logic                    o_w_done,
  output logic                    o_w_pass,
  output logic [N_IN:0]           o_w_mismatch
);

  localparam int unsigned DEPTH = 2**N_IN;
  localparam int unsigned MW    = N_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic [DEPTH-1:0]   r_table;
  logic [DEPTH-1:0]   r_covered;
  logic               r_conflict;
  logic               r_done;
  logic               r_pass;
  logic [MW-1:0]      r_mismatch;

  logic               w_accept;
  logic [DEPTH-1:0]   w_table_nxt;
  logic [DEPTH-1:0]   w_cov_nxt;
  logic               w_conflict_nxt;
  logic               w_all_cov;
  logic [DEPTH-1:0]   w_diff;
  logic [MW-1:0]      w_mismatch_nxt;
  logic               w_pass_nxt;

  // Sample absorption; a start in the same cycle takes priority and drops the sample.
  always_comb begin
    w_accept       = (r_state == S_COLLECT) & r_ready & i_w_valid & ~i_w_start;
    w_table_nxt    = r_table;
    w_cov_nxt      = r_covered;
    w_conflict_nxt = r_conflict;
    if (w_accept) begin
      if (!r_covered[i_w_in]) begin
        w_table_nxt[i_w_in] = i_w_out;
        w_cov_nxt[i_w_in]   = 1'b1;
      end else if (r_table[i_w_in] != i_w_out) begin
        w_conflict_nxt = 1'b1;
      end
    end
    w_all_cov = &w_cov_nxt;
  end

  // Verdict computed from the post-update table so it is ready on the DONE transition.
  always_comb begin
    w_diff         = w_table_nxt ^ EXPECTED;
    w_mismatch_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_mismatch_nxt = w_mismatch_nxt + MW'(w_diff[i]);
    end
    w_pass_nxt = (w_table_nxt == EXPECTED) & ~w_conflict_nxt;
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_table    <= '0;
      r_covered  <= '0;
      r_conflict <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mismatch <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_w_start) begin
            r_state    <= S_COLLECT;
            r_ready    <= 1'b1;
            r_table    <= '0;
            r_covered  <= '0;
            r_conflict <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (i_w_start) begin
            r_table    <= '0;
            r_covered  <= '0;
            r_conflict <= 1'b0;
          end else begin
            r_table    <= w_table_nxt;
            r_covered  <= w_cov_nxt;
            r_conflict <= w_conflict_nxt;
            if (w_all_cov) begin
              r_state    <= S_DONE;
              r_ready    <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= w_pass_nxt;
              r_mismatch <= w_mismatch_nxt;
            end
          end
        end
        S_DONE: begin
          if (i_w_start) begin
            r_state    <= S_COLLECT;
            r_ready    <= 1'b1;
            r_table    <= '0;
            r_covered  <= '0;
            r_conflict <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
          r_mismatch <= '0;
        end
      endcase
    end
  end

  assign o_w_ready    = r_ready;
  assign o_w_table    = r_table;
  assign o_w_covered  = r_covered;
  assign o_w_conflict = r_conflict;
  assign o_w_done     = r_done;
  assign o_w_pass     = r_pass;
  assign o_w_mismatch = r_mismatch;

endmodule

// File: tb/tb_comb_tt_checker.sv
// Bench for comb_tt_checker: vector table, directed corner sequences and random runs
// checked against a truth-table model.
module tb_comb_tt_checker;

  localparam logic [7:0] EXP = 8'hE8;

  logic       clk, rst;
  logic       i_start, i_valid, i_out;
  logic [2:0] i_in;
  logic       o_ready, o_conflict, o_done, o_pass;
  logic [7:0] o_table, o_covered;
  logic [3:0] o_mismatch;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 collecting, 2 verdict available.
  int         m_mode;
  logic [7:0] m_tab, m_cov;
  logic       m_conf;

  typedef struct {
    logic       start, valid;
    logic [2:0] in;
    logic       out;
    logic       e_ready;
    logic [7:0] e_table, e_cov;
    logic       e_done, e_pass;
    logic [3:0] e_mm;
  } vec_t;

  comb_tt_checker #(.N_IN(3), .EXPECTED(8'hE8)) dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(i_start), .i_w_valid(i_valid),
    .o_w_ready(o_ready), .i_w_in(i_in), .i_w_out(i_out), .o_w_table(o_table),
    .o_w_covered(o_covered), .o_w_conflict(o_conflict), .o_w_done(o_done),
    .o_w_pass(o_pass), .o_w_mismatch(o_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tab = '0; m_cov = '0; m_conf = 1'b0;
  endtask

  task automatic model_clear();
    m_tab = '0; m_cov = '0; m_conf = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic v, input logic [2:0] in, input logic out);
    if (m_mode == 0) begin
      if (st) begin model_clear(); m_mode = 1; end
    end else if (m_mode == 1) begin
      if (st) model_clear();
      else if (v) begin
        if (!m_cov[in]) begin m_tab[in] = out; m_cov[in] = 1'b1; end
        else if (m_tab[in] != out) m_conf = 1'b1;
        if (m_cov == 8'hFF) m_mode = 2;
      end
    end else if (st) begin
      model_clear(); m_mode = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic       e_done, e_pass;
    logic [3:0] e_mm;
    e_done = (m_mode == 2);
    e_pass = e_done && (m_tab == EXP) && !m_conf;
    e_mm   = e_done ? 4'($countones(m_tab ^ EXP)) : 4'd0;
    chk({tag, ".ready"},    32'(o_ready),    32'(m_mode == 1));
    chk({tag, ".table"},    32'(o_table),    32'(m_tab));
    chk({tag, ".covered"},  32'(o_covered),  32'(m_cov));
    chk({tag, ".conflict"}, 32'(o_conflict), 32'(m_conf));
    chk({tag, ".done"},     32'(o_done),     32'(e_done));
    chk({tag, ".pass"},     32'(o_pass),     32'(e_pass));
    chk({tag, ".mismatch"}, 32'(o_mismatch), 32'(e_mm));
  endtask

  task automatic apply(input string tag, input logic st, input logic v,
                       input logic [2:0] in, input logic out);
    i_start = st; i_valid = v; i_in = in; i_out = out;
    @(posedge clk);
    model_edge(st, v, in, out);
    #1;
    i_start = 1'b0;
    check_all(tag);
  endtask

  task automatic feed_all(input string tag, input logic [7:0] tt);
    logic [7:0] t;
    t = tt;
    for (int i = 0; i < 8; i++) apply(tag, 1'b0, 1'b1, 3'(i), t[i]);
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0] e;
    logic       rs, rv, ro;
    logic [2:0] ri;
    int         cyc;
    e = EXP;
    rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_in = '0; i_out = 1'b0;
    model_reset();

    // Reset with no clock edge yet
    #1 rst = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(negedge clk) rst = 1'b0;

    // Valid ignored in IDLE
    for (int k = 0; k < 5; k++) apply("idle", 1'b0, 1'b1, 3'd3, 1'b1);

    // Majority table, in order, with per-step expectations
    vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 4'd0};
    vecs[3] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h08, 8'h0F, 1'b0, 1'b0, 4'd0};
    vecs[5] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 8'h08, 8'h1F, 1'b0, 1'b0, 4'd0};
    vecs[6] = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'h28, 8'h3F, 1'b0, 1'b0, 4'd0};
    vecs[7] = '{1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 8'h68, 8'h7F, 1'b0, 1'b0, 4'd0};
    vecs[8] = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 8'hE8, 8'hFF, 1'b1, 1'b1, 4'd0};
    for (int k = 0; k < 9; k++) begin
      apply("vec", vecs[k].start, vecs[k].valid, vecs[k].in, vecs[k].out);
      chk("vec.ready",    32'(o_ready),    32'(vecs[k].e_ready));
      chk("vec.table",    32'(o_table),    32'(vecs[k].e_table));
      chk("vec.covered",  32'(o_covered),  32'(vecs[k].e_cov));
      chk("vec.done",     32'(o_done),     32'(vecs[k].e_done));
      chk("vec.pass",     32'(o_pass),     32'(vecs[k].e_pass));
      chk("vec.mismatch", 32'(o_mismatch), 32'(vecs[k].e_mm));
    end

    // One wrong minterm
    apply("wrong", 1'b1, 1'b0, 3'd0, 1'b0);
    feed_all("wrong", 8'hE9);
    chk("wrong.table", 32'(o_table), 32'h E9);
    chk("wrong.pass", 32'(o_pass), 32'd0);
    chk("wrong.mismatch", 32'(o_mismatch), 32'd1);
    chk("wrong.conflict", 32'(o_conflict), 32'd0);

    // Conflicting repeat keeps the first value and kills the verdict
    apply("conf", 1'b1, 1'b0, 3'd0, 1'b0);
    apply("conf", 1'b0, 1'b1, 3'd5, 1'b1);
    apply("conf", 1'b0, 1'b1, 3'd5, 1'b0);
    chk("conf.flag", 32'(o_conflict), 32'd1);
    chk("conf.t5", 32'(o_table[5]), 32'd1);
    for (int i = 0; i < 8; i++) if (i != 5) apply("conf", 1'b0, 1'b1, 3'(i), e[i]);
    chk("conf.done", 32'(o_done), 32'd1);
    chk("conf.pass", 32'(o_pass), 32'd0);
    chk("conf.mismatch", 32'(o_mismatch), 32'd0);

    // Restart mid-collection (sample alongside start is dropped), then restart from DONE
    apply("rst_mid", 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) apply("rst_mid", 1'b0, 1'b1, 3'(i), e[i]);
    apply("rst_mid", 1'b1, 1'b1, 3'd4, 1'b0);
    chk("rst_mid.covered", 32'(o_covered), 32'h00);
    feed_all("rst_mid", e);
    chk("rst_mid.table", 32'(o_table), 32'hE8);
    chk("rst_mid.pass", 32'(o_pass), 32'd1);
    apply("from_done", 1'b1, 1'b0, 3'd0, 1'b0);
    chk("from_done.ready", 32'(o_ready), 32'd1);
    chk("from_done.done", 32'(o_done), 32'd0);

    // Async reset between edges while collecting
    for (int i = 0; i < 3; i++) apply("areset", 1'b0, 1'b1, 3'(i), e[i]);
    @(negedge clk) rst = 1'b1;
    #1 model_reset();
    check_all("areset.imm");
    chk("areset.covered", 32'(o_covered), 32'h00);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) apply("areset.idle", 1'b0, 1'b1, 3'(i), e[i]);
    chk("areset.done0", 32'(o_done), 32'd0);
    apply("areset", 1'b1, 1'b0, 3'd0, 1'b0);
    feed_all("areset", e);
    chk("areset.done1", 32'(o_done), 32'd1);

    // Random runs: arbitrary order, gaps, duplicates, rare errors and restarts
    for (int r = 0; r < 25; r++) begin
      apply("rand", 1'b1, 1'b0, 3'd0, 1'b0);
      cyc = 0;
      while (m_mode != 2 && cyc < 2000) begin
        rs = ($urandom_range(0, 63) == 0);
        rv = ($urandom_range(0, 3) != 0);
        ri = 3'($urandom_range(0, 7));
        ro = e[ri] ^ ($urandom_range(0, 15) == 0);
        apply("rand", rs, rv, ri, ro);
        cyc++;
      end
      chk("rand.done", 32'(o_done), 32'd1);
      for (int k = 0; k < 3; k++)
        apply("rand.hold", 1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
